// File: rtl/fp_div_arbiter_pkg.sv
// rtl/fp_div_arbiter_pkg.sv - shared state type and constants for the FP32 divider arbiter
package div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] QNAN            = 32'h7FC00000;
  localparam int          DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// rtl/fp_div_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW:0]   slot_sum;
  logic [IW-1:0] slot;

  // Walk offsets from the far end so the smallest offset from ptr is written last and wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    slot_sum = '0;
    slot     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot_sum = {1'b0, ptr} + (IW+1)'(k);
      if (slot_sum >= (IW+1)'(NREQ)) begin
        slot_sum = slot_sum - (IW+1)'(NREQ);
      end
      slot = slot_sum[IW-1:0];
      if (req[slot]) begin
        grant       = '0;
        grant[slot] = 1'b1;
        idx         = slot;
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - shares one iterative FP32 divider among NREQ requesters; DIV_ARB_TIMEOUT_EN adds a WAIT watchdog
module fp_div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_err,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_busy,
  input  logic                  div_valid,
  input  logic [WIDTH-1:0]      div_result
);

  localparam int IW = $clog2(NREQ);

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n, win, win_n, pick_idx;
  logic [NREQ-1:0]  pick_gnt, gnt_n, rv_n;
  logic [WIDTH-1:0] rdata_n, a_n, b_n;
  logic             start_n, rerr_n;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_gnt),
    .idx   (pick_idx)
  );

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          timed_out;
  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0) || (QNAN == '0);
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    gnt_n   = '0;
    rv_n    = '0;
    start_n = 1'b0;
    rdata_n = resp_data;
    rerr_n  = resp_err;
    a_n     = div_a;
    b_n     = div_b;
`ifdef DIV_ARB_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          win_n   = pick_idx;
          gnt_n   = pick_gnt;
          start_n = 1'b1;
          a_n     = req_a[int'(pick_idx)*WIDTH +: WIDTH];
          b_n     = req_b[int'(pick_idx)*WIDTH +: WIDTH];
          ptr_n   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE:  state_n = SETTLE;
      // The divider still shows the previous result's valid here; it is deliberately ignored.
      SETTLE: begin
        state_n = WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      WAIT: begin
        if (div_valid && !div_busy) begin
          rdata_n   = div_result;
          rerr_n    = 1'b0;
          rv_n[win] = 1'b1;
          state_n   = RESP;
        end
`ifdef DIV_ARB_TIMEOUT_EN
        else if (timed_out) begin
          rdata_n   = WIDTH'(QNAN);
          rerr_n    = 1'b1;
          rv_n[win] = 1'b1;
          state_n   = RESP;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
`endif
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      win        <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      win        <= win_n;
      gnt        <= gnt_n;
      resp_valid <= rv_n;
      resp_data  <= rdata_n;
      resp_err   <= rerr_n;
      div_start  <= start_n;
      div_a      <= a_n;
      div_b      <= b_n;
`ifdef DIV_ARB_TIMEOUT_EN
      wait_cnt   <= wait_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb/tb_fp_div_arbiter.sv - randomized bench for fp_div_arbiter with a table-driven divider stub
module tb_fp_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 16;
  localparam int NTAB = 8;

  localparam logic [31:0] TAB_A [NTAB] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h41000000,
                                           32'h3F800000, 32'hC1100000, 32'h41200000, 32'h00000000};
  localparam logic [31:0] TAB_B [NTAB] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h40800000,
                                           32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  localparam logic [31:0] TAB_Q [NTAB] = '{32'h40400000, 32'h3F800000, 32'h7F800000, 32'h40000000,
                                           32'h3F000000, 32'hC0400000, 32'h40200000, 32'h00000000};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   gnt, resp_valid;
  logic [W-1:0]      resp_data, div_a, div_b, div_result;
  logic              resp_err, div_start, div_busy, div_valid;

  fp_div_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_busy   (div_busy),
    .div_valid  (div_valid),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_bad = 0;
  int          opi [NREQ];
  int          m_ptr = 0, cur = 0, since = 0, exp_lat = 0, next_lat = 1, just = -1;
  bit          m_idle = 1'b1, reopen = 1'b0, inflight = 1'b0, rand_on = 1'b0, stub_hang = 1'b0;
  logic [31:0] exp_q = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 0) || (b[30:0] == 0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    for (int t = 0; t < NTAB; t++) if (TAB_A[t] == a && TAB_B[t] == b) return TAB_Q[t];
    return 32'hDEADBEEF;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Divider stub: reacts one cycle after start, so the previous valid is still visible in SETTLE.
  logic [31:0] stub_a, stub_b;
  logic        stub_go;
  int          stub_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0; div_valid <= 1'b0; div_result <= '0;
      stub_go <= 1'b0; stub_a <= '0; stub_b <= '0; stub_cnt <= 0;
    end else begin
      stub_go <= div_start;
      if (div_start) begin
        stub_a <= div_a;
        stub_b <= div_b;
      end
      if (stub_go) begin
        if (special(stub_a, stub_b)) begin
          div_busy <= 1'b0; div_valid <= 1'b1; div_result <= ref_q(stub_a, stub_b);
        end else begin
          div_busy <= 1'b1; div_valid <= 1'b0; div_result <= 32'h0BAD0BAD;
          stub_cnt <= stub_hang ? 0 : next_lat;
        end
      end else if (div_busy && stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          div_busy <= 1'b0; div_valid <= 1'b1; div_result <= ref_q(stub_a, stub_b);
        end
      end
    end
  end

  task automatic issue(input int i, input int t);
    opi[i] = t;
    req_a[i*W +: W] = TAB_A[t];
    req_b[i*W +: W] = TAB_B[t];
    req[i] = 1'b1;
  endtask

  task automatic step();
    logic [NREQ-1:0] exp_g, exp_rv;
    int w;
    @(negedge clk);
    exp_g = '0; exp_rv = '0; w = -1;
    if (inflight) since++;
    if (m_idle && req != '0) begin
      w = pick(req, m_ptr);
      exp_g[w] = 1'b1;
    end
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("div_start", 32'(div_start), 32'(w >= 0));
    if (w >= 0) begin
      chk("div_a", div_a, TAB_A[opi[w]]);
      chk("div_b", div_b, TAB_B[opi[w]]);
      m_ptr = (w + 1) % NREQ; m_idle = 1'b0; inflight = 1'b1; cur = w; since = 0;
      next_lat = $urandom_range(1, 20);
      exp_q    = TAB_Q[opi[w]];
      exp_err  = 1'b0;
      exp_lat  = special(TAB_A[opi[w]], TAB_B[opi[w]]) ? 3 : 3 + next_lat;
`ifdef DIV_ARB_TIMEOUT_EN
      if (stub_hang) begin
        exp_lat = 2 + TO; exp_q = 32'h7FC00000; exp_err = 1'b1;
      end
`endif
      if ($urandom_range(0, 1) == 1) req_a[w*W +: W] = $urandom;
    end else if (inflight) begin
      chk("div_a_hold", div_a, TAB_A[opi[cur]]);
      chk("div_b_hold", div_b, TAB_B[opi[cur]]);
    end
    if (inflight && since == exp_lat) exp_rv[cur] = 1'b1;
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    just = -1;
    if (exp_rv != '0) begin
      chk("resp_data", resp_data, exp_q);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      req[cur] = 1'b0; inflight = 1'b0; reopen = 1'b1; just = cur;
    end else if (reopen) begin
      m_idle = 1'b1; reopen = 1'b0;
    end
    if (rand_on) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && i != just && $urandom_range(0, 3) == 0) issue(i, $urandom_range(0, NTAB - 1));
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((inflight || reopen || req != '0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 32'(inflight || reopen || req != '0), 32'd0);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    req = '0; inflight = 1'b0; reopen = 1'b0; m_idle = 1'b1; m_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    @(negedge clk);
    apply_reset();

    issue(0, 0);
    drain(100);
    issue(2, 2);
    drain(100);

    apply_reset();
    for (int i = 0; i < NREQ; i++) issue(i, $urandom_range(0, NTAB - 1));
    rand_on = 1'b1;
    repeat (300) step();
    rand_on = 1'b0;
    drain(300);

    issue(1, 0);
    n = 0;
    while (!(inflight && since == 2) && n < 50) begin
      step();
      n++;
    end
    chk("reach_wait", 32'(inflight && since == 2), 32'd1);
    apply_reset();
    repeat (6) step();
    issue(3, 1);
    drain(100);

`ifdef DIV_ARB_TIMEOUT_EN
    stub_hang = 1'b1;
    issue(1, 0);
    drain(100);
    stub_hang = 1'b0;
`endif

    rand_on = 1'b1;
    repeat (1500) step();
    rand_on = 1'b0;
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin scheduler that shares one iterative single-precision (IEEE-754 FP32) divider among NREQ requesters. It grants one requester at a time and latches that requester's operands. It then sequences the divider's start/busy/valid handshake and returns the quotient to the granted requester with a one-cycle response pulse. It sits between the FP compute clients and the single divider instance in the IEEE_754_Single_Precision datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the timeout feature)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level
- req_a  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  divisors, same packing
- gnt  out  NREQ  one-hot grant pulse, one cycle
- resp_valid  out  NREQ  one-hot response pulse, one cycle
- resp_data  out  WIDTH  quotient, valid while any resp_valid bit is high
- resp_err  out  1  timeout flag, qualified by resp_valid
- div_start  out  1  start to divider
- div_a, div_b  out  WIDTH  operands to divider, held stable from ISSUE through WAIT
- div_busy  in  1  divider busy
- div_valid  in  1  divider result valid
- div_result  in  WIDTH  divider output

## Operation
- All outputs are registered.
- States:
  - IDLE: if any req bit is set, the rr_arbiter picks the winner starting at ptr. The block latches the winner index, loads div_a/div_b from the winner's slice, pulses gnt, sets ptr = (winner+1) mod NREQ, and goes to ISSUE. With no request it stays in IDLE.
  - ISSUE: div_start=1 for exactly this cycle, then SETTLE.
  - SETTLE: div_start=0, one cycle. This absorbs the divider's stale div_valid. Then WAIT.
  - WAIT: on div_valid=1 and div_busy=0, capture div_result into resp_data, set resp_err=0, go to RESP.
  - RESP: resp_valid[winner]=1 for one cycle, then IDLE.
- div_valid is never sampled in IDLE, ISSUE or SETTLE.
- Special operands (zero, Inf/NaN exponent) make the divider assert div_valid without asserting busy. This is caught in the first WAIT cycle.
- Requester rule: hold req and operands stable until resp_valid[i] is seen, then deassert req on the next edge. The arbiter does not re-grant a requester in the cycle its response is pulsed.
- Operands are latched at grant; changes after gnt are ignored.
- Simultaneous requests: lowest index at or above ptr wins, wrapping modulo NREQ.
- Reset (including mid-transaction):
  - gnt, resp_valid, resp_data, resp_err, div_start, div_a, div_b all go to 0.
  - ptr goes to 0 and state to IDLE.
  - Any in-flight transaction is dropped with no response. The divider shares rst.

## Timing
- Request seen in IDLE at edge E: gnt high in cycle E+1 (ISSUE), SETTLE at E+2, WAIT from E+3.
- Normal divide: divider computes for about 27 cycles; resp_valid follows one cycle after WAIT captures.
- Special operand: resp_valid at E+4 (capture at E+3, RESP at E+4).
- The next grant can issue in the cycle after RESP (back-to-back throughput = latency + 1).

## Configuration
- DIV_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider WAIT counter resets on entering WAIT.
  - When it reaches TIMEOUT_CYCLES without a capture, the block goes to RESP with resp_err=1 and resp_data=32'h7FC00000 (quiet NaN).
- Not defined: no counter; WAIT holds indefinitely and resp_err is tied 0.

## Structure
- Package div_arb_pkg:
  - state enum (IDLE, ISSUE, SETTLE, WAIT, RESP)
  - QNAN constant 32'h7FC00000
  - DEFAULT_TIMEOUT
- Sub-module rr_arbiter: combinational round-robin priority pick. Inputs req and ptr; outputs one-hot grant and encoded index.

## Test plan
- Single request: req[0], a=0x40C00000 (6.0), b=0x40000000 (2.0) → gnt[0] one cycle, div_start one cycle, resp_valid[0] with resp_data=0x40400000 (3.0), resp_err=0.
- Special operand: req[2], a=0x3F800000, b=0x00000000 → resp_data=0x7F800000 four cycles after the grant edge.
- Contention: req[3:0]=4'b1111 held, ptr=0 → grants in order 0,1,2,3,0; no requester granted twice before the others are served.
- Operand hold: change req_a[1] right after gnt[1] → result still reflects the latched operands.
- Reset mid-WAIT: assert rst during divider compute → all outputs 0, no resp_valid. Then a fresh request with 1.0/1.0 → 0x3F800000.
- DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, stub divider holding busy=1 → resp_valid with resp_err=1 and resp_data=0x7FC00000 after 16 WAIT cycles.
